// File: rtl/uart_receive.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// uart_receive
//   8N1 UART receiver. The asynchronous rx line is brought into the clk_in
//   domain through a two-flop synchroniser, the start bit is re-checked at its
//   centre to reject glitches, each data bit and the stop bit are sampled once
//   at their nominal centre, and every frame ends in either a one-cycle
//   valid_out pulse (good stop bit) or a one-cycle frame_err_out pulse (stop
//   bit low, byte discarded). After a framing error the receiver waits for the
//   line to return high, so a held-low line (break) never starts a new frame.
//
// Parameters
//   INPUT_CLOCK_FREQ  clk_in frequency in Hz
//   BAUD_RATE         line rate in bits/s
//
// Ports
//   clk_in         in   system clock
//   rst_n_in       in   asynchronous active-low reset
//   rx_wire_in     in   raw serial line, idle high, asynchronous to clk_in
//   data_out       out  [7:0] last correctly framed byte (LSB received first)
//   valid_out      out  one-cycle pulse, data_out updated this cycle
//   frame_err_out  out  one-cycle pulse, stop bit sampled low
//   busy_out       out  high whenever the receiver is not idle
// -----------------------------------------------------------------------------
module uart_receive #(
  parameter int INPUT_CLOCK_FREQ = 100_000_000,
  parameter int BAUD_RATE        = 9600
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic       rx_wire_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       frame_err_out,
  output logic       busy_out
);

  localparam int BAUD_BIT_PERIOD = INPUT_CLOCK_FREQ / BAUD_RATE;
  localparam int HALF            = BAUD_BIT_PERIOD / 2;
  localparam int CNT_W           = $clog2(BAUD_BIT_PERIOD);

  localparam logic [CNT_W-1:0] CNT_HALF_END = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] CNT_BIT_END  = CNT_W'(BAUD_BIT_PERIOD - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  // Synchroniser
  logic r_sync1;
  logic r_sync2;
  logic w_rx_s;

  // FSM and datapath
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;
  logic [7:0]       r_data;
  logic             r_valid;
  logic             r_frame_err;
  logic             r_busy;

  // NOTE: the synchroniser resets to 1 (line idle) rather than 0, otherwise
  // the first cycles after reset would look like a start bit.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make r_sync2 take the old r_sync1,
      // which is what gives two real flop stages.
      r_sync1 <= rx_wire_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_rx_s = r_sync2;

  // Every state change clears r_cnt, so each state measures its own interval
  // from zero. START waits half a bit so that all later samples, taken one
  // full bit period apart, land on bit centres.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      // NOTE: pulses default low every cycle; only the STOP decision below
      // raises one, which guarantees single-cycle width.
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (!w_rx_s) begin
            r_state <= S_START;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end

        S_START: begin
          if (r_cnt == CNT_HALF_END) begin
            r_cnt <= '0;
            if (!w_rx_s) begin
              r_state   <= S_DATA;
              r_bit_idx <= '0;
            end else begin
              // Line went back high before mid-start: treat as a glitch.
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        S_DATA: begin
          if (r_cnt == CNT_BIT_END) begin
            r_cnt              <= '0;
            r_shift[r_bit_idx] <= w_rx_s;
            if (r_bit_idx == 3'd7) begin
              r_state <= S_STOP;
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        S_STOP: begin
          // Leaving at mid-stop gives half a bit of slack to catch a start
          // edge that follows the stop bit with no idle time.
          if (r_cnt == CNT_BIT_END) begin
            r_cnt <= '0;
            if (w_rx_s) begin
              r_data  <= r_shift;
              r_valid <= 1'b1;
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_frame_err <= 1'b1;
              r_state     <= S_BREAK;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        S_BREAK: begin
          // Stay here while the line is held low so a break cannot be
          // mistaken for a new start bit.
          if (w_rx_s) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign data_out      = r_data;
  assign valid_out     = r_valid;
  assign frame_err_out = r_frame_err;
  assign busy_out      = r_busy;

endmodule
